alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU (WIDTH-bit, 4-bit gs opcode, z/n/c/v flags) between NREQ requesters.
- Each requester presents operands and opcode with a request.
- A round-robin arbiter grants one request per cycle and issues it to the ALU.
- Result, flags and requester ID are captured in a single-entry output register with valid/ready backpressure. The block sits between the decode/issue stages and the shared execute unit.

Parameters:
- WIDTH, 32, operand/result width passed to the ALU instance.
- NREQ, 4, number of requesters (2..16; non-power-of-2 allowed).
- IDW, max(1, clog2(NREQ)), width of the requester ID field.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_req  input  NREQ  per-requester request; held high with operands stable until granted.
- i_a  input  NREQ*WIDTH  packed A operands; requester k occupies bits [k*WIDTH +: WIDTH].
- i_b  input  NREQ*WIDTH  packed B operands, same packing as i_a.
- i_gs  input  NREQ*4  packed ALU opcodes; requester k occupies [k*4 +: 4].
- o_gnt  output  NREQ  one-hot accept strobe (combinational); the request is consumed in the cycle o_gnt[k]=1.
- o_rsp_valid  output  1  result register holds a valid response.
- i_rsp_ready  input  1  consumer accepts the response this cycle.
- o_rsp_id  output  IDW  index of the requester that produced the response.
- o_rsp_out  output  WIDTH  ALU result.
- o_rsp_flags  output  4  {z,n,c,v} from the ALU for that result.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - o_rsp_valid=0; o_rsp_id, o_rsp_out, o_rsp_flags = 0.
  - Round-robin pointer ptr=0.
  - o_gnt is forced to 0 while i_rst is high.
- Slot free: free = !o_rsp_valid || i_rsp_ready.
- Grant (combinational):
  - If free and |i_req, grant the first requester with i_req set, searching ptr, ptr+1, ... NREQ-1, 0, ... ptr-1.
  - o_gnt is exactly one-hot or zero.
  - Never grant when !free.
- Issue:
  - The granted requester's i_a/i_b/i_gs slices are muxed onto the ALU inputs.
  - The ALU output is combinational. On the clock edge, o_rsp_out, o_rsp_flags and o_rsp_id load from the ALU and the grant index, and o_rsp_valid becomes 1.
- Latency and throughput:
  - Grant in cycle T → response valid in cycle T+1.
  - Sustained throughput is one op per cycle while i_rsp_ready=1.
- Pointer update: on grant of k, ptr <= (k+1) mod NREQ, with explicit wrap for non-power-of-2 NREQ. With no grant, ptr holds.
- Response drain:
  - If o_rsp_valid && i_rsp_ready and no grant this cycle, o_rsp_valid <= 0.
  - Simultaneous drain and grant: the register reloads and o_rsp_valid stays 1.
- Backpressure: if o_rsp_valid && !i_rsp_ready, the register and all outputs hold, o_gnt=0, and ptr holds.
- Request withdrawal: requesters must not drop i_req before grant. Behaviour is unspecified if they do, but no X may propagate to o_gnt.
- Fairness: a continuously requesting requester is granted within NREQ grant cycles.
- Reset mid-operation: a pending response is discarded (valid cleared). Requests present during reset are not granted and are arbitrated from ptr=0 after reset releases.
- Flags:
  - Taken unmodified from the ALU.
  - z derives from the result; c and v are only meaningful for arithmetic opcodes (gs[3]=0).
  - The arbiter adds no flag interpretation.

Decomposition:
- Package alu_ctrl_pkg holds:
  - Flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
  - Opcode constant GS_ADD=4'b0000.
  - The clog2 helper used for IDW.
- Sub-module rr_arbiter (NREQ): i_clk, i_rst, i_req, i_en (=free), o_gnt one-hot, o_idx. It owns ptr and the update rule.
- Top level owns the operand mux, the ALU instance and the response register.

Test Plan:
- Reset: assert i_rst for 2 cycles with all i_req=1 → o_gnt=0, o_rsp_valid=0, all outputs 0. First grant after release goes to requester 0.
- Single op: req1 with a=5, b=3, gs=GS_ADD → o_gnt=0010 in cycle T; cycle T+1 gives o_rsp_valid=1, id=1, out=8, flags=0000.
- Round-robin: all four requesting continuously with i_rsp_ready=1 → grants 0,1,2,3,0,... one per cycle. Ptr wraps 3→0; no requester waits more than 4 cycles.
- Backpressure: hold i_rsp_ready=0 for 3 cycles with response valid → outputs stable, o_gnt=0, ptr unchanged. Release → same-cycle drain plus new grant, valid stays 1.
- Flags: a=0x7FFFFFFF, b=1, ADD → out=0x80000000, n=1, v=1, c=0, z=0. Then a=0xFFFFFFFF, b=1 → out=0, z=1, c=1, v=0.
- Reset mid-stream: assert i_rst while o_rsp_valid=1 and i_rsp_ready=0 → valid cleared next edge, ptr=0, and the pending response is never presented.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU arbitration slice: flag bit positions,
// ALU opcodes and the ID-width helper used to size requester indices.
package alu_ctrl_pkg;

    // Bit positions inside the 4-bit {z,n,c,v} flag vector
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Opcodes: gs[3]=0 arithmetic (c/v meaningful), gs[3]=1 logical.
    // Any other encoding yields a zero result with c=v=0.
    localparam logic [3:0] GS_ADD = 4'b0000;
    localparam logic [3:0] GS_SUB = 4'b0001;
    localparam logic [3:0] GS_AND = 4'b1000;
    localparam logic [3:0] GS_OR  = 4'b1001;
    localparam logic [3:0] GS_XOR = 4'b1010;
    localparam logic [3:0] GS_NOT = 4'b1011;

    // ceil(log2(n)), never less than 1 so a 1-bit index always exists
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU. Ports: i_a/i_b operands, i_gs opcode, o_out result,
// o_flags {z,n,c,v}. c is carry-out for ADD and no-borrow for SUB; c and v
// are zero for logical and unused opcodes.
module alu
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_gs,
    output logic [WIDTH-1:0] o_out,
    output logic [3:0]       o_flags
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   dif_s;
    logic [WIDTH-1:0] out_s;
    logic             c_s;
    logic             v_s;

    // Operation select and flag generation
    always_comb begin
        sum_s = {1'b0, i_a} + {1'b0, i_b};
        dif_s = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
        out_s = '0;
        c_s   = 1'b0;
        v_s   = 1'b0;
        case (i_gs)
            GS_ADD: begin
                out_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (out_s[WIDTH-1] != i_a[WIDTH-1]);
            end
            GS_SUB: begin
                out_s = dif_s[WIDTH-1:0];
                c_s   = dif_s[WIDTH];
                v_s   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (out_s[WIDTH-1] != i_a[WIDTH-1]);
            end
            GS_AND:  out_s = i_a & i_b;
            GS_OR:   out_s = i_a | i_b;
            GS_XOR:  out_s = i_a ^ i_b;
            GS_NOT:  out_s = ~i_a;
            default: out_s = '0;
        endcase
        o_out          = out_s;
        o_flags        = 4'b0000;
        o_flags[FLAG_Z] = (out_s == '0);
        o_flags[FLAG_N] = out_s[WIDTH-1];
        o_flags[FLAG_C] = c_s;
        o_flags[FLAG_V] = v_s;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. Searches ptr, ptr+1, ... wrapping at NREQ and grants
// the first active request while i_en is high and reset is low.
// Ports: i_clk/i_rst (sync, active-high), i_req request vector, i_en slot
// free, o_gnt one-hot grant (combinational), o_idx index of the grant.
module rr_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2_min1(NREQ)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx
);

    localparam logic [IDW:0]   NREQ_W   = (IDW + 1)'(NREQ);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    logic [IDW-1:0]  ptr_r;
    logic [NREQ-1:0] gnt_s;
    logic [IDW-1:0]  idx_s;
    logic            found_s;
    logic            hit_s;
    logic [IDW:0]    sum_s;
    logic [IDW:0]    cand_s;

    // Rotating priority search; the extra index bit lets ptr+off exceed
    // NREQ-1 so the wrap works for non-power-of-two NREQ.
    always_comb begin
        gnt_s   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int off = 0; off < NREQ; off++) begin
            sum_s  = {1'b0, ptr_r} + off[IDW:0];
            cand_s = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
            hit_s  = !found_s && i_en && !i_rst && i_req[cand_s[IDW-1:0]];
            gnt_s[cand_s[IDW-1:0]] = gnt_s[cand_s[IDW-1:0]] | hit_s;
            idx_s   = hit_s ? cand_s[IDW-1:0] : idx_s;
            found_s = found_s | hit_s;
        end
    end

    // Pointer moves past the winner; holds when nothing is granted
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_r <= '0;
        end else if (found_s) begin
            ptr_r <= (idx_s == LAST_IDX) ? '0 : (idx_s + IDW'(1));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign o_gnt = gnt_s;
    assign o_idx = idx_s;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters. A round-robin arbiter picks one
// request per cycle when the response slot is free; the result, flags and
// requester ID land in a single-entry register drained by valid/ready.
// Ports: i_clk, i_rst (sync, active-high), i_req/i_a/i_b/i_gs packed
// per-requester inputs, o_gnt one-hot accept strobe, o_rsp_* response
// register outputs, i_rsp_ready consumer acceptance.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = clog2_min1(NREQ)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*WIDTH-1:0] i_a,
    input  logic [NREQ*WIDTH-1:0] i_b,
    input  logic [NREQ*4-1:0]     i_gs,
    output logic [NREQ-1:0]       o_gnt,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [IDW-1:0]        o_rsp_id,
    output logic [WIDTH-1:0]      o_rsp_out,
    output logic [3:0]            o_rsp_flags
);

    logic [WIDTH-1:0] a_arr_s  [NREQ];
    logic [WIDTH-1:0] b_arr_s  [NREQ];
    logic [3:0]       gs_arr_s [NREQ];

    logic             free_s;
    logic [NREQ-1:0]  gnt_s;
    logic [IDW-1:0]   idx_s;
    logic             any_gnt_s;
    logic [WIDTH-1:0] alu_out_s;
    logic [3:0]       alu_flags_s;

    logic             rsp_valid_r;
    logic [IDW-1:0]   rsp_id_r;
    logic [WIDTH-1:0] rsp_out_r;
    logic [3:0]       rsp_flags_r;

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign a_arr_s[k]  = i_a[k*WIDTH +: WIDTH];
        assign b_arr_s[k]  = i_b[k*WIDTH +: WIDTH];
        assign gs_arr_s[k] = i_gs[k*4 +: 4];
    end

    // A slot is free when empty or when the current response leaves this cycle
    assign free_s    = !rsp_valid_r || i_rsp_ready;
    assign any_gnt_s = |gnt_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (i_req),
        .i_en  (free_s),
        .o_gnt (gnt_s),
        .o_idx (idx_s)
    );

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a     (a_arr_s[idx_s]),
        .i_b     (b_arr_s[idx_s]),
        .i_gs    (gs_arr_s[idx_s]),
        .o_out   (alu_out_s),
        .o_flags (alu_flags_s)
    );

    // Response register: load on grant (covers same-cycle drain+reload),
    // clear valid on a drain without grant, otherwise hold
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_out_r   <= '0;
            rsp_flags_r <= 4'b0000;
        end else if (any_gnt_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= idx_s;
            rsp_out_r   <= alu_out_s;
            rsp_flags_r <= alu_flags_s;
        end else if (i_rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    assign o_gnt       = gnt_s;
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_id    = rsp_id_r;
    assign o_rsp_out   = rsp_out_r;
    assign o_rsp_flags = rsp_flags_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a behavioural reference model:
// arithmetic done on 64-bit integers, round-robin as a modular search.
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 64'sd1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a;
    logic [NREQ*WIDTH-1:0] b;
    logic [NREQ*4-1:0]     gs;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_out;
    logic [3:0]            rsp_flags;

    alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_a         (a),
        .i_b         (b),
        .i_gs        (gs),
        .o_gnt       (gnt),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_rsp_out   (rsp_out),
        .o_rsp_flags (rsp_flags)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    bit        m_valid;
    int        m_id;
    bit [31:0] m_out;
    bit [3:0]  m_flags;
    int        m_ptr;
    int        wait_cnt [NREQ];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void alu_ref(input bit [3:0] op, input bit [31:0] x, input bit [31:0] y,
                                    output bit [31:0] r, output bit [3:0] f);
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        bit c = 1'b0;
        bit v = 1'b0;
        case (op)
            4'd0: begin
                r = 32'(ux + uy);
                c = (ux + uy) > 64'sd4294967295;
                v = (sx + sy > SMAX) || (sx + sy < SMIN);
            end
            4'd1: begin
                r = 32'(ux - uy);
                c = ux >= uy;
                v = (sx - sy > SMAX) || (sx - sy < SMIN);
            end
            4'd8:    r = x & y;
            4'd9:    r = x | y;
            4'd10:   r = x ^ y;
            4'd11:   r = ~x;
            default: r = 32'd0;
        endcase
        f = {r == 32'd0, r[31], c, v};
    endfunction

    task automatic set_req(input int k, input bit [3:0] op, input bit [31:0] x, input bit [31:0] y);
        req[k]          = 1'b1;
        a[k*WIDTH +: WIDTH] = x;
        b[k*WIDTH +: WIDTH] = y;
        gs[k*4 +: 4]    = op;
    endtask

    function automatic bit [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic bit [3:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 4'd0;
            1:       return 4'd1;
            2:       return 4'd8;
            3:       return 4'd9;
            4:       return 4'd10;
            5:       return 4'd11;
            default: return 4'($urandom);
        endcase
    endfunction

    // One clock: check at negedge against the model, advance model, retire grant
    task automatic step(output int g);
        bit [31:0] r;
        bit [3:0]  f;
        int        k;
        @(negedge clk);
        g = -1;
        if (!rst && (!m_valid || rsp_ready)) begin
            for (int off = 0; off < NREQ; off++) begin
                k = (m_ptr + off) % NREQ;
                if (g < 0 && req[k]) g = k;
            end
        end
        check_eq("gnt", gnt, (g >= 0) ? (64'd1 << g) : 64'd0);
        check_eq("valid", rsp_valid, m_valid);
        check_eq("id", rsp_id, m_id);
        check_eq("out", rsp_out, m_out);
        check_eq("flags", rsp_flags, m_flags);
        if (g >= 0) begin
            check_eq("fairness", wait_cnt[g] < NREQ, 1);
            for (int j = 0; j < NREQ; j++) if (j != g && req[j]) wait_cnt[j]++;
            wait_cnt[g] = 0;
        end
        if (rst) begin
            m_valid = 1'b0; m_id = 0; m_out = 32'd0; m_flags = 4'd0; m_ptr = 0;
            for (int j = 0; j < NREQ; j++) wait_cnt[j] = 0;
        end else if (g >= 0) begin
            alu_ref(gs[g*4 +: 4], a[g*WIDTH +: WIDTH], b[g*WIDTH +: WIDTH], r, f);
            m_valid = 1'b1; m_id = g; m_out = r; m_flags = f;
            m_ptr = (g + 1) % NREQ;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (g >= 0) req[g] = 1'b0;
    endtask

    initial begin
        int g;
        rst = 1'b1; req = '0; a = '0; b = '0; gs = '0; rsp_ready = 1'b1;
        m_valid = 1'b0; m_id = 0; m_out = 32'd0; m_flags = 4'd0; m_ptr = 0;
        for (int j = 0; j < NREQ; j++) wait_cnt[j] = 0;

        // Reset with every requester active
        for (int k = 0; k < NREQ; k++) set_req(k, 4'd0, 32'(k + 1), 32'd10);
        step(g); step(g);
        rst = 1'b0;
        for (int i = 0; i < 8 && req != '0; i++) step(g);
        step(g);

        // Single op from requester 1
        set_req(1, 4'd0, 32'd5, 32'd3);
        step(g);
        check_eq("single_valid", rsp_valid, 1);
        check_eq("single_id", rsp_id, 1);
        check_eq("single_out", rsp_out, 8);
        check_eq("single_flags", rsp_flags, 4'b0000);
        step(g);

        // All four requesting continuously
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < NREQ; k++) if (!req[k]) set_req(k, rand_op(), rand_opnd(), rand_opnd());
            step(g);
        end

        // Backpressure for three cycles, then release
        rsp_ready = 1'b0;
        for (int k = 0; k < NREQ; k++) if (!req[k]) set_req(k, rand_op(), rand_opnd(), rand_opnd());
        step(g); step(g); step(g);
        rsp_ready = 1'b1;
        step(g);
        check_eq("bp_release_valid", rsp_valid, 1);
        for (int i = 0; i < 8 && req != '0; i++) step(g);
        step(g);

        // Flag corner cases
        set_req(2, 4'd0, 32'h7FFF_FFFF, 32'd1);
        step(g);
        check_eq("ovf_out", rsp_out, 32'h8000_0000);
        check_eq("ovf_flags", rsp_flags, 4'b0101);
        set_req(3, 4'd0, 32'hFFFF_FFFF, 32'd1);
        step(g);
        check_eq("carry_out", rsp_out, 32'h0000_0000);
        check_eq("carry_flags", rsp_flags, 4'b1010);
        step(g);

        // Reset with a stalled response pending
        rsp_ready = 1'b0;
        set_req(2, 4'd1, 32'd9, 32'd4);
        step(g);
        set_req(1, 4'd8, 32'hF0F0_F0F0, 32'hFF00_FF00);
        set_req(3, 4'd9, 32'd1, 32'd2);
        rst = 1'b1;
        step(g);
        rst = 1'b0;
        check_eq("rst_mid_valid", rsp_valid, 0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step(g);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NREQ; k++)
                if (!req[k] && $urandom_range(0, 1) == 1) set_req(k, rand_op(), rand_opnd(), rand_opnd());
            rsp_ready = ($urandom_range(0, 3) != 0);
            step(g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
